// File: rtl/nibble_serial_subtractor_16_bit.sv
// 16-bit subtractor that works through A - B - Bin one nibble per clock,
// using a 4-bit ripple with a borrow-skip bypass when the nibbles are equal.
module nibble_serial_subtractor_16_bit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] A,
   input  logic [15:0] B,
   input  logic        Bin,
   output logic        busy,
   output logic        done,
   output logic [15:0] Diff,
   output logic        Bout,
   output logic        V
);

   typedef enum logic {IDLE, CALC} state_t;

   state_t      r_state;
   logic [1:0]  r_cnt;
   logic        r_borrow;
   logic [15:0] r_a;
   logic [15:0] r_b;
   logic [15:0] r_work;
   logic [15:0] r_diff;
   logic        r_bout;
   logic        r_v;
   logic        r_done;

   logic [3:0]  w_an;
   logic [3:0]  w_bn;
   logic [3:0]  w_sum;
   logic [4:0]  w_carry;
   logic        w_skip;
   logic        w_borrowNext;

   // Subtraction as A + ~B + ~borrow; the carry-out is the inverted borrow.
   always_comb begin
      w_an       = r_a[{r_cnt, 2'b00} +: 4];
      w_bn       = r_b[{r_cnt, 2'b00} +: 4];
      w_sum      = 4'h0;
      w_carry    = 5'h00;
      w_carry[0] = ~r_borrow;
      for (int i = 0; i < 4; i++) begin
         w_sum[i]       = w_an[i] ^ ~w_bn[i] ^ w_carry[i];
         w_carry[i + 1] = (w_an[i] & ~w_bn[i]) | (w_carry[i] & (w_an[i] ^ ~w_bn[i]));
      end
      w_skip       = &(w_an ~^ w_bn);
      w_borrowNext = w_skip ? r_borrow : ~w_carry[4];
   end

   assign busy = (r_state == CALC);
   assign done = r_done;
   assign Diff = r_diff;
   assign Bout = r_bout;
   assign V    = r_v;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_cnt    <= 2'd0;
         r_borrow <= 1'b0;
         r_a      <= 16'h0000;
         r_b      <= 16'h0000;
         r_work   <= 16'h0000;
         r_diff   <= 16'h0000;
         r_bout   <= 1'b0;
         r_v      <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_a      <= A;
                  r_b      <= B;
                  r_borrow <= Bin;
                  r_cnt    <= 2'd0;
                  r_work   <= 16'h0000;
                  r_state  <= CALC;
               end
            end
            CALC: begin
               r_work[{r_cnt, 2'b00} +: 4] <= w_sum;
               r_borrow <= w_borrowNext;
               r_cnt    <= r_cnt + 2'd1;
               // Last nibble: publish the full result straight from this cycle's datapath.
               if (r_cnt == 2'd3) begin
                  r_diff  <= {w_sum, r_work[11:0]};
                  r_bout  <= w_borrowNext;
                  r_v     <= (r_a[15] ^ r_b[15]) & (r_a[15] ^ w_sum[3]);
                  r_done  <= 1'b1;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_serial_subtractor_16_bit.sv
// Self-checking bench: directed and random subtractions compared against
// plain 17-bit arithmetic, plus busy-start, reset-abort and back-to-back cases.
module tb_nibble_serial_subtractor_16_bit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] A;
   logic [15:0] B;
   logic        Bin;
   logic        busy;
   logic        done;
   logic [15:0] Diff;
   logic        Bout;
   logic        V;

   int checks = 0;
   int passes = 0;

   logic [15:0] lastDiff;
   logic        lastBout;
   logic        lastV;

   nibble_serial_subtractor_16_bit dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .A    (A),
      .B    (B),
      .Bin  (Bin),
      .busy (busy),
      .done (done),
      .Diff (Diff),
      .Bout (Bout),
      .V    (V)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed === expected)
         passes++;
      else
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
   endtask

   // One full operation; optionally scrambles inputs and pulses start while busy.
   task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic bin, input bit disturb);
      logic [16:0] full;
      logic [15:0] eDiff;
      logic        eBout;
      logic        eV;
      full  = {1'b0, a} - {1'b0, b} - {16'h0000, bin};
      eDiff = full[15:0];
      eBout = full[16];
      eV    = (a[15] ^ b[15]) & (a[15] ^ eDiff[15]);

      @(negedge clk);
      A = a; B = b; Bin = bin; start = 1'b1;
      @(posedge clk); #1;
      checkOutput("busyAfterStart", {31'b0, busy}, 32'd1);
      checkOutput("doneLowAfterStart", {31'b0, done}, 32'd0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (disturb) begin
            A     = 16'($urandom);
            B     = 16'($urandom);
            Bin   = 1'($urandom);
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         if (c < 3) begin
            checkOutput("busyHold", {31'b0, busy}, 32'd1);
            checkOutput("noEarlyDone", {31'b0, done}, 32'd0);
            checkOutput("diffHeld", {16'b0, Diff}, {16'b0, lastDiff});
            checkOutput("boutHeld", {31'b0, Bout}, {31'b0, lastBout});
            checkOutput("vHeld", {31'b0, V}, {31'b0, lastV});
         end
      end
      start = 1'b0;
      checkOutput("doneHigh", {31'b0, done}, 32'd1);
      checkOutput("busyLowAtDone", {31'b0, busy}, 32'd0);
      checkOutput("diff", {16'b0, Diff}, {16'b0, eDiff});
      checkOutput("bout", {31'b0, Bout}, {31'b0, eBout});
      checkOutput("v", {31'b0, V}, {31'b0, eV});
      lastDiff = eDiff;
      lastBout = eBout;
      lastV    = eV;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; A = 16'h0000; B = 16'h0000; Bin = 1'b0;
      lastDiff = 16'h0000; lastBout = 1'b0; lastV = 1'b0;
      #12;
      checkOutput("resetBusy", {31'b0, busy}, 32'd0);
      checkOutput("resetDone", {31'b0, done}, 32'd0);
      checkOutput("resetDiff", {16'b0, Diff}, 32'd0);
      checkOutput("resetBout", {31'b0, Bout}, 32'd0);
      checkOutput("resetV", {31'b0, V}, 32'd0);
      @(negedge clk); rst = 1'b0;

      applyStimulus(16'h1234, 16'h0234, 1'b0, 1'b0);
      applyStimulus(16'h0000, 16'h0001, 1'b0, 1'b0);
      applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b0);
      applyStimulus(16'h5555, 16'h5555, 1'b1, 1'b0);
      applyStimulus(16'h5555, 16'h5555, 1'b0, 1'b0);
      applyStimulus(16'h0010, 16'h0001, 1'b0, 1'b1);
      applyStimulus(16'h7FFF, 16'hFFFF, 1'b1, 1'b0);

      // Hold start low after the done cycle: no further done must appear.
      @(negedge clk); start = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         checkOutput("idleNoDone", {31'b0, done}, 32'd0);
      end

      // Abort an operation with an asynchronous reset in mid-flight.
      @(negedge clk);
      A = 16'hFFFF; B = 16'h0001; Bin = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      @(posedge clk);
      @(negedge clk); #2; rst = 1'b1; #1;
      checkOutput("abortBusy", {31'b0, busy}, 32'd0);
      checkOutput("abortDone", {31'b0, done}, 32'd0);
      checkOutput("abortDiff", {16'b0, Diff}, 32'd0);
      checkOutput("abortBout", {31'b0, Bout}, 32'd0);
      checkOutput("abortV", {31'b0, V}, 32'd0);
      @(negedge clk); rst = 1'b0;
      lastDiff = 16'h0000; lastBout = 1'b0; lastV = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         checkOutput("noDoneAfterAbort", {31'b0, done}, 32'd0);
      end

      applyStimulus(16'h0003, 16'h0005, 1'b0, 1'b0);
      applyStimulus(16'h4321, 16'h1234, 1'b1, 1'b0);

      for (int n = 0; n < 40; n++) begin
         logic [15:0] ra;
         logic [15:0] rb;
         ra = 16'($urandom);
         rb = (n % 5 == 0) ? ra : 16'($urandom);
         applyStimulus(ra, rb, 1'($urandom), 1'(n % 2));
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
